// File: rtl/pipe_reg_pkg.sv
// ============================================================================
//  Module      : pipe_reg_pkg
//  Description : Shared types and helper functions for the pipe_reg pipeline.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_reg_pkg;

    // Per-stage control: load takes new data and sets valid, clear drops valid.
    typedef struct packed {
        logic load;
        logic clear;
    } stage_ctrl_t;

    // Width needed to count 0..depth valid stages.
    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_stage.sv
// ============================================================================
//  Module      : pipe_stage
//  Description : One data/valid register pair with load and clear controls.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_stage
    import pipe_reg_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  stage_ctrl_t      i_ctrl,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid
);

    logic [WIDTH-1:0] r_data;
    logic             r_valid;

    // Data only changes on a load, so bubbles never toggle the register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (i_ctrl.load) begin
            r_data  <= i_data;
            r_valid <= 1'b1;
        end else if (i_ctrl.clear) begin
            r_valid <= 1'b0;
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;

endmodule

`default_nettype wire

// File: rtl/pipe_reg.sv
// ============================================================================
//  Module      : pipe_reg
//  Description : Bubble-collapsing valid/ready register pipeline with clock
//                enable and flush. Define PIPE_REG_OCC_EN to add the
//                registered occupancy output.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_reg
    import pipe_reg_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef PIPE_REG_OCC_EN
    ,
    output logic [occ_width(DEPTH)-1:0] occupancy
`endif
);

    localparam int c_OCC_W = occ_width(DEPTH);

    if (WIDTH < 1 || DEPTH < 1) begin : g_bad_param
        $error("%m: pipe_reg needs WIDTH >= 1 and DEPTH >= 1");
    end

    logic [WIDTH-1:0] w_d [DEPTH];
    logic [DEPTH-1:0] w_v;
    logic [DEPTH-1:0] w_move;
    logic             w_tail_full;

    // A valid stage advances when any later stage is empty or the tail drains;
    // this is the unrolled form of the bubble-collapsing move chain.
    always_comb begin
        w_move      = '0;
        w_tail_full = 1'b1;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            w_move[i]   = ce & w_v[i] & (~w_tail_full | out_ready);
            w_tail_full = w_tail_full & w_v[i];
        end
    end

    assign in_ready  = ce & ~flush & (~w_v[0] | w_move[0]);
    assign out_valid = w_v[DEPTH-1];
    assign out_data  = w_d[DEPTH-1];

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        logic [WIDTH-1:0] w_din;
        stage_ctrl_t      w_ctrl;

        if (g == 0) begin : g_head
            assign w_din       = in_data;
            assign w_ctrl.load = in_valid & in_ready;
        end else begin : g_body
            assign w_din       = w_d[g-1];
            assign w_ctrl.load = ~flush & w_move[g-1];
        end

        assign w_ctrl.clear = flush | w_move[g];

        pipe_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .i_ctrl  (w_ctrl),
            .i_data  (w_din),
            .o_data  (w_d[g]),
            .o_valid (w_v[g])
        );
    end

`ifdef PIPE_REG_OCC_EN
    logic [c_OCC_W-1:0] r_occ;
    logic               w_accept;
    logic               w_deliver;

    assign w_accept  = in_valid & in_ready;
    assign w_deliver = w_move[DEPTH-1];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_occ <= '0;
        end else begin
            r_occ <= r_occ + c_OCC_W'(w_accept) - c_OCC_W'(w_deliver);
        end
    end

    assign occupancy = r_occ;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_reg.sv
// ============================================================================
//  Module      : tb_pipe_reg
//  Description : Self-checking bench for pipe_reg against a slot-based model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_reg;

    localparam int W = 16;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst, ce, flush, in_valid, out_ready;
    logic         in_ready, out_valid;
    logic [W-1:0] in_data, out_data;
`ifdef PIPE_REG_OCC_EN
    logic [$clog2(D+1)-1:0] occupancy;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Model: one slot per stage; words slide forward into free slots.
    bit           m_v [D];
    logic [W-1:0] m_d [D];

    pipe_reg #(.WIDTH(W), .DEPTH(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .ce        (ce),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef PIPE_REG_OCC_EN
        ,
        .occupancy (occupancy)
`endif
    );

    always #5 clk = ~clk;

    function automatic bit model_ready();
        bit v [D];
        v = m_v;
        if (!ce || flush) return 1'b0;
        if (v[D-1] && out_ready) v[D-1] = 1'b0;
        for (int i = D - 2; i >= 0; i--)
            if (v[i] && !v[i+1]) begin v[i+1] = 1'b1; v[i] = 1'b0; end
        return !v[0];
    endfunction

    function automatic int model_count();
        int n = 0;
        for (int i = 0; i < D; i++) n += int'(m_v[i]);
        return n;
    endfunction

    task automatic model_edge();
        if (rst) begin
            for (int i = 0; i < D; i++) begin m_v[i] = 1'b0; m_d[i] = '0; end
        end else if (flush) begin
            for (int i = 0; i < D; i++) m_v[i] = 1'b0;
        end else if (ce) begin
            if (m_v[D-1] && out_ready) m_v[D-1] = 1'b0;
            for (int i = D - 2; i >= 0; i--)
                if (m_v[i] && !m_v[i+1]) begin
                    m_d[i+1] = m_d[i]; m_v[i+1] = 1'b1; m_v[i] = 1'b0;
                end
            if (!m_v[0] && in_valid) begin m_d[0] = in_data; m_v[0] = 1'b1; end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(input logic r, input logic c, input logic f,
                         input logic iv, input logic [W-1:0] d, input logic ordy);
        rst = r; ce = c; flush = f; in_valid = iv; in_data = d; out_ready = ordy;
        #1;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 2; c++) begin
            drive(1, 1, 0, 1, W'($urandom), 0);
            step();
        end
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_out: got v=%b d=%h want v=0 d=0000", out_valid, out_data);
        end
`ifdef PIPE_REG_OCC_EN
        n_checks++;
        if (occupancy !== 3'd0) begin
            n_fail++; $display("FAIL reset_occ: got %0d want 0", occupancy);
        end
`endif
    endtask

    task automatic test_streaming();
        for (int c = 0; c < 14; c++) begin
            drive(0, 1, 0, c < 8, W'(c + 1), 1);
            n_checks++;
            if (in_ready !== model_ready()) begin
                n_fail++; $display("FAIL stream_ready c=%0d: got %b", c, in_ready);
            end
            step();
            n_checks++;
            if (out_valid !== (c >= 3 && c <= 10) ||
                (c >= 3 && c <= 10 && out_data !== W'(c - 2))) begin
                n_fail++;
                $display("FAIL stream_out c=%0d: got v=%b d=%h want v=%b d=%h",
                         c, out_valid, out_data, (c >= 3 && c <= 10), W'(c - 2));
            end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] words [6];
        logic [W-1:0] got [$];
        int acc = 0;
        for (int i = 0; i < 6; i++) words[i] = W'($urandom);
        for (int c = 0; c < 6; c++) begin
            drive(0, 1, 0, acc < 6, words[acc % 6], 0);
            n_checks++;
            if (in_ready !== model_ready()) begin
                n_fail++; $display("FAIL bp_ready c=%0d: got %b", c, in_ready);
            end
            if (in_valid && in_ready) acc++;
            step();
        end
        drive(0, 1, 0, 1, words[acc % 6], 0);
        n_checks++;
        if (acc != 4 || in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== words[0]) begin
            n_fail++;
            $display("FAIL bp_full: acc=%0d rdy=%b v=%b d=%h want acc=4 rdy=0 v=1 d=%h",
                     acc, in_ready, out_valid, out_data, words[0]);
        end
`ifdef PIPE_REG_OCC_EN
        n_checks++;
        if (occupancy !== 3'd4) begin
            n_fail++; $display("FAIL bp_occ: got %0d want 4", occupancy);
        end
`endif
        for (int c = 0; c < 14; c++) begin
            drive(0, 1, 0, acc < 6, words[acc % 6], 1);
            if (out_valid) got.push_back(out_data);
            if (in_valid && in_ready) acc++;
            step();
        end
        n_checks++;
        if (got.size() != 6) begin
            n_fail++; $display("FAIL bp_count: got %0d words want 6", got.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                n_checks++;
                if (got[i] !== words[i]) begin
                    n_fail++; $display("FAIL bp_order[%0d]: got %h want %h", i, got[i], words[i]);
                end
            end
        end
    endtask

    task automatic test_bubbles();
        logic [W-1:0] a, b;
        a = W'($urandom); b = W'($urandom);
        for (int c = 0; c < 6; c++) begin
            drive(0, 1, 0, c == 0 || c == 2, (c == 0) ? a : b, 0);
            step();
        end
        drive(0, 1, 0, 0, '0, 0);
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== a || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bubble_hold: v=%b d=%h rdy=%b want v=1 d=%h rdy=1",
                     out_valid, out_data, in_ready, a);
        end
`ifdef PIPE_REG_OCC_EN
        n_checks++;
        if (occupancy !== 3'd2) begin
            n_fail++; $display("FAIL bubble_occ: got %0d want 2", occupancy);
        end
`endif
        drive(0, 1, 0, 0, '0, 1);
        step();
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== b) begin
            n_fail++; $display("FAIL bubble_second: v=%b d=%h want v=1 d=%h", out_valid, out_data, b);
        end
        step();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL bubble_empty: v=%b want 0", out_valid);
        end
    endtask

    task automatic test_ce_gating();
        logic [W-1:0] words [10];
        logic [W-1:0] got [$];
        logic         hold_v;
        logic [W-1:0] hold_d;
        int acc = 0;
        for (int i = 0; i < 10; i++) words[i] = W'($urandom);
        for (int c = 0; c < 24; c++) begin
            drive(0, !(c >= 4 && c < 7), 0, acc < 10, words[acc % 10], 1);
            if (c == 4) begin hold_v = out_valid; hold_d = out_data; end
            if (!ce) begin
                n_checks++;
                if (in_ready !== 1'b0) begin
                    n_fail++; $display("FAIL ce_ready c=%0d: got %b want 0", c, in_ready);
                end
            end
            if (out_valid && ce) got.push_back(out_data);
            if (in_valid && in_ready) acc++;
            step();
            if (c >= 4 && c < 7) begin
                n_checks++;
                if (out_valid !== hold_v || out_data !== hold_d) begin
                    n_fail++;
                    $display("FAIL ce_hold c=%0d: v=%b d=%h want v=%b d=%h",
                             c, out_valid, out_data, hold_v, hold_d);
                end
            end
        end
        n_checks++;
        if (got.size() != 10) begin
            n_fail++; $display("FAIL ce_count: got %0d words want 10", got.size());
        end else begin
            for (int i = 0; i < 10; i++) begin
                n_checks++;
                if (got[i] !== words[i]) begin
                    n_fail++; $display("FAIL ce_order[%0d]: got %h want %h", i, got[i], words[i]);
                end
            end
        end
    endtask

    task automatic test_flush();
        for (int c = 0; c < 3; c++) begin drive(0, 1, 0, 1, W'($urandom), 0); step(); end
        drive(0, 1, 1, 1, W'($urandom), 0);
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++; $display("FAIL flush_ready: got %b want 0", in_ready);
        end
        step();
`ifdef PIPE_REG_OCC_EN
        n_checks++;
        if (occupancy !== 3'd0) begin
            n_fail++; $display("FAIL flush_occ: got %0d want 0", occupancy);
        end
`endif
        for (int c = 0; c < 5; c++) begin
            drive(0, 1, 0, 0, '0, 1);
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++; $display("FAIL flush_drop c=%0d: v=%b want 0", c, out_valid);
            end
            step();
        end
        // Flush coinciding with an output transfer must not replay the word.
        for (int c = 0; c < 4; c++) begin drive(0, 1, 0, 1, W'($urandom), 0); step(); end
        drive(0, 1, 1, 0, '0, 1);
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++; $display("FAIL flush_xfer_pre: v=%b want 1", out_valid);
        end
        for (int c = 0; c < 4; c++) begin
            step();
            drive(0, 1, 0, 0, '0, 1);
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++; $display("FAIL flush_replay c=%0d: v=%b want 0", c, out_valid);
            end
        end
        for (int c = 0; c < 4; c++) begin
            drive(0, 1, 0, 1, W'($urandom) | 16'h0001, 0); step();
        end
        drive(1, 1, 1, 1, W'($urandom), 1);
        step();
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== 16'h0000) begin
            n_fail++; $display("FAIL rst_over_flush: v=%b d=%h want v=0 d=0000", out_valid, out_data);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            drive($urandom_range(0, 63) == 0, $urandom_range(0, 9) != 0,
                  $urandom_range(0, 31) == 0, $urandom_range(0, 9) < 7,
                  W'($urandom), $urandom_range(0, 9) < 6);
            n_checks++;
            if (in_ready !== model_ready()) begin
                n_fail++; $display("FAIL rand_ready c=%0d: got %b want %b", c, in_ready, model_ready());
            end
            step();
            n_checks++;
            if (out_valid !== m_v[D-1] || out_data !== m_d[D-1]) begin
                n_fail++;
                $display("FAIL rand_out c=%0d: v=%b d=%h want v=%b d=%h",
                         c, out_valid, out_data, m_v[D-1], m_d[D-1]);
            end
`ifdef PIPE_REG_OCC_EN
            n_checks++;
            if (int'(occupancy) != model_count()) begin
                n_fail++; $display("FAIL rand_occ c=%0d: got %0d want %0d", c, occupancy, model_count());
            end
`endif
        end
    endtask

    initial begin
        rst = 1'b1; ce = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_bubbles();
        test_ce_gating();
        test_flush();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
